// File: rtl/sobel_pkg.sv
// sobel_pkg
// Shared constants, types and helpers for the Sobel gradient core.
//   DATA_W  : pixel width (input window pixels and output pixel)
//   GRAD_W  : signed gradient / unsigned magnitude width (DATA_W+3)
//   pix_t   : unsigned pixel
//   grad_t  : signed gradient component (Gx or Gy)
//   mag_t   : unsigned |Gx|+|Gy|
// Optional feature macro used by the files of this block: SOBEL_THRESH_EN.
package sobel_pkg;

    localparam int DATA_W = 8;
    localparam int GRAD_W = DATA_W + 3;

    typedef logic        [DATA_W-1:0] pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic        [GRAD_W-1:0] mag_t;

    localparam pix_t PIX_MAX     = '1;
    localparam mag_t PIX_MAX_MAG = mag_t'(2**DATA_W - 1);

    // The most negative gradient is -1020, so negation never overflows GRAD_W bits.
    function automatic mag_t abs_grad(input grad_t g);
        return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
    endfunction

    function automatic pix_t sat_pix(input mag_t mag);
        return (mag > PIX_MAX_MAG) ? PIX_MAX : mag[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_if.sv
// sobel_if
// Bundles the window input bus and the pixel output bus of sobel_core.
//   master : upstream side (drives core_en_i, data_r_c_i, threshold_i; sees outputs)
//   slave  : the core itself
// threshold_i exists only when SOBEL_THRESH_EN is defined.
interface sobel_if #(
    parameter int CNT_W = 10
);
    import sobel_pkg::*;

    logic             core_en_i;
    pix_t             data_0_0_i, data_0_1_i, data_0_2_i;
    pix_t             data_1_0_i, data_1_1_i, data_1_2_i;
    pix_t             data_2_0_i, data_2_1_i, data_2_2_i;
`ifdef SOBEL_THRESH_EN
    pix_t             threshold_i;
`endif
    pix_t             pix_o;
    logic             pix_valid_o;
    logic [CNT_W-1:0] out_col_o;
    logic [CNT_W-1:0] out_row_o;
    logic             row_done_o;
    logic             frame_done_o;

    modport master (
        output core_en_i,
        output data_0_0_i, data_0_1_i, data_0_2_i,
        output data_1_0_i, data_1_1_i, data_1_2_i,
        output data_2_0_i, data_2_1_i, data_2_2_i,
`ifdef SOBEL_THRESH_EN
        output threshold_i,
`endif
        input  pix_o, pix_valid_o, out_col_o, out_row_o, row_done_o, frame_done_o
    );

    modport slave (
        input  core_en_i,
        input  data_0_0_i, data_0_1_i, data_0_2_i,
        input  data_1_0_i, data_1_1_i, data_1_2_i,
        input  data_2_0_i, data_2_1_i, data_2_2_i,
`ifdef SOBEL_THRESH_EN
        input  threshold_i,
`endif
        output pix_o, pix_valid_o, out_col_o, out_row_o, row_done_o, frame_done_o
    );

endinterface

// File: rtl/sobel_grad.sv
// sobel_grad
// First pipeline stage: registered Sobel Gx/Gy of one 3x3 window.
//   clk, rst        : clock, synchronous active-high reset
//   dRC_i           : window pixel at row R, column C
//   gx_o, gy_o      : registered signed gradients
module sobel_grad
    import sobel_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  pix_t  d00_i, d01_i, d02_i,
    input  pix_t  d10_i, d11_i, d12_i,
    input  pix_t  d20_i, d21_i, d22_i,
    output grad_t gx_o,
    output grad_t gy_o
);

    grad_t gx_d, gx_q;
    grad_t gy_d, gy_q;

    function automatic grad_t ext(input pix_t p);
        return grad_t'({{(GRAD_W-DATA_W){1'b0}}, p});
    endfunction

    // Each weighted sum is at most 1020, which fits the signed GRAD_W range.
    // The centre pixel has zero weight in both kernels.
    always_comb begin
        gx_d = (ext(d02_i) + ext(d12_i) + ext(d12_i) + ext(d22_i))
             - (ext(d00_i) + ext(d10_i) + ext(d10_i) + ext(d20_i));
        gy_d = (ext(d20_i) + ext(d21_i) + ext(d21_i) + ext(d22_i))
             - (ext(d00_i) + ext(d01_i) + ext(d01_i) + ext(d02_i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_q <= '0;
            gy_q <= '0;
        end else begin
            gx_q <= gx_d;
            gy_q <= gy_d;
        end
    end

    assign gx_o = gx_q;
    assign gy_o = gy_q;

    logic unused_centre;
    assign unused_centre = ^d11_i;

endmodule

// File: rtl/sobel_core.sv
// sobel_core
// 3-stage Sobel gradient magnitude core with output position tracking.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sobel_if.slave (window in, pixel + position + row/frame pulses out)
// Parameters: MAX_COL/MAX_ROW input image size, CNT_W position counter width.
// Optional SOBEL_THRESH_EN: binarize the saturated magnitude against threshold_i.
module sobel_core
    import sobel_pkg::*;
#(
    parameter int MAX_COL = 540,
    parameter int MAX_ROW = 540,
    parameter int CNT_W   = 10
) (
    input  logic    clk,
    input  logic    rst,
    sobel_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(MAX_COL - 3);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MAX_ROW - 3);

    grad_t            gx_s1, gy_s1;
    logic             v1_d, v1_q;
    logic             v2_d, v2_q;
    mag_t             mag_d, mag_q;
`ifdef SOBEL_THRESH_EN
    pix_t             thr_d, thr_q;
`endif
    pix_t             pix_d, pix_q;
    logic             pix_valid_d, pix_valid_q;
    logic [CNT_W-1:0] col_cnt_d, col_cnt_q;
    logic [CNT_W-1:0] row_cnt_d, row_cnt_q;
    logic [CNT_W-1:0] out_col_d, out_col_q;
    logic [CNT_W-1:0] out_row_d, out_row_q;
    logic             row_done_d, row_done_q;
    logic             frame_done_d, frame_done_q;

    sobel_grad u_grad (
        .clk   (clk),
        .rst   (rst),
        .d00_i (bus.data_0_0_i), .d01_i (bus.data_0_1_i), .d02_i (bus.data_0_2_i),
        .d10_i (bus.data_1_0_i), .d11_i (bus.data_1_1_i), .d12_i (bus.data_1_2_i),
        .d20_i (bus.data_2_0_i), .d21_i (bus.data_2_1_i), .d22_i (bus.data_2_2_i),
        .gx_o  (gx_s1),
        .gy_o  (gy_s1)
    );

    // col_cnt/row_cnt hold the position of the next pixel to leave S3; the
    // out_* registers are loaded from them together with pix so that the
    // reported position always belongs to the pixel on pix_o and holds
    // through bubbles.
    always_comb begin
        v1_d         = bus.core_en_i;
        v2_d         = v1_q;
        mag_d        = abs_grad(gx_s1) + abs_grad(gy_s1);
`ifdef SOBEL_THRESH_EN
        thr_d        = bus.threshold_i;
        pix_d        = (sat_pix(mag_q) >= thr_q) ? PIX_MAX : '0;
`else
        pix_d        = sat_pix(mag_q);
`endif
        pix_valid_d  = v2_q;
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        row_done_d   = 1'b0;
        frame_done_d = 1'b0;

        if (v2_q) begin
            out_col_d    = col_cnt_q;
            out_row_d    = row_cnt_q;
            row_done_d   = (col_cnt_q == LAST_COL);
            frame_done_d = (col_cnt_q == LAST_COL) && (row_cnt_q == LAST_ROW);
            if (col_cnt_q == LAST_COL) begin
                col_cnt_d = '0;
                row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            mag_q        <= '0;
`ifdef SOBEL_THRESH_EN
            thr_q        <= '0;
`endif
            pix_q        <= '0;
            pix_valid_q  <= 1'b0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            mag_q        <= mag_d;
`ifdef SOBEL_THRESH_EN
            thr_q        <= thr_d;
`endif
            pix_q        <= pix_d;
            pix_valid_q  <= pix_valid_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pix_o        = pix_q;
    assign bus.pix_valid_o  = pix_valid_q;
    assign bus.out_col_o    = out_col_q;
    assign bus.out_row_o    = out_row_q;
    assign bus.row_done_o   = row_done_q;
    assign bus.frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_core.sv
// tb_sobel_core
// Directed bench for sobel_core on a small 8x5 image (6 outputs per row, 3 rows).
// Windows are packed MSB first as d00,d01,d02,d10,d11,d12,d20,d21,d22.
// Honours SOBEL_THRESH_EN when it is defined for the build.
module tb_sobel_core;
    import sobel_pkg::*;

    localparam int CNT_W = 4;

    localparam logic [71:0] W_FLAT  = {9{8'd100}};
    localparam logic [71:0] W_R255  = {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
    localparam logic [71:0] W_GX80  = {8'd0, 8'd10, 8'd20, 8'd0, 8'd10, 8'd20, 8'd0, 8'd10, 8'd20};
    localparam logic [71:0] W_GY200 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd50, 8'd50};
    localparam logic [71:0] W_D22   = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100};
    localparam logic [71:0] W_NEGL  = {8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0};
    localparam logic [71:0] W_G254  = {8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd63, 8'd0, 8'd0, 8'd64};
    localparam logic [71:0] W_G256  = {8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd64};
    localparam logic [71:0] W_D00   = {8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    localparam logic [71:0] W_G78   = {8'd0, 8'd10, 8'd20, 8'd0, 8'd10, 8'd19, 8'd0, 8'd10, 8'd20};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   check_count = 0;
    int   error_count = 0;
    int   thr_level   = 128;

    always #5 clk = ~clk;

    sobel_if #(.CNT_W(CNT_W)) bus ();

    sobel_core #(
        .MAX_COL (8),
        .MAX_ROW (5),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected output pixel for a window of known |Gx|+|Gy|.
    function automatic logic [31:0] expPix(input int mag);
        int s;
        s = (mag > 255) ? 255 : mag;
`ifdef SOBEL_THRESH_EN
        return (s >= thr_level) ? 32'd255 : 32'd0;
`else
        return 32'(s);
`endif
    endfunction

    task automatic applyStimulus(input logic en, input logic [71:0] w);
        bus.core_en_i = en;
        {bus.data_0_0_i, bus.data_0_1_i, bus.data_0_2_i,
         bus.data_1_0_i, bus.data_1_1_i, bus.data_1_2_i,
         bus.data_2_0_i, bus.data_2_1_i, bus.data_2_2_i} = w;
`ifdef SOBEL_THRESH_EN
        bus.threshold_i = pix_t'(thr_level);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) else begin
            error_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkPixel(input string tag, input logic [31:0] pix, input int col,
                              input int row, input logic rd, input logic fd);
        checkOutput({tag, "_valid"}, 32'(bus.pix_valid_o), 32'd1);
        checkOutput({tag, "_pix"}, 32'(bus.pix_o), pix);
        checkOutput({tag, "_col"}, 32'(bus.out_col_o), 32'(col));
        checkOutput({tag, "_row"}, 32'(bus.out_row_o), 32'(row));
        checkOutput({tag, "_rowdone"}, 32'(bus.row_done_o), 32'(rd));
        checkOutput({tag, "_framedone"}, 32'(bus.frame_done_o), 32'(fd));
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        applyStimulus(1'b0, '0);
        applyStimulus(1'b0, '0);
        checkOutput("rst_valid", 32'(bus.pix_valid_o), 32'd0);
        checkOutput("rst_pix", 32'(bus.pix_o), 32'd0);
        checkOutput("rst_col", 32'(bus.out_col_o), 32'd0);
        checkOutput("rst_row", 32'(bus.out_row_o), 32'd0);
        checkOutput("rst_rowdone", 32'(bus.row_done_o), 32'd0);
        checkOutput("rst_framedone", 32'(bus.frame_done_o), 32'd0);
        rst = 1'b0;

        // Flat window: zero gradient, exactly three cycles of latency
        applyStimulus(1'b1, W_FLAT);
        checkOutput("lat_c1", 32'(bus.pix_valid_o), 32'd0);
        applyStimulus(1'b0, '0);
        checkOutput("lat_c2", 32'(bus.pix_valid_o), 32'd0);
        applyStimulus(1'b0, '0);
        checkPixel("flat", 32'd0, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0);
        checkOutput("flat_after_valid", 32'(bus.pix_valid_o), 32'd0);
        checkOutput("flat_after_col", 32'(bus.out_col_o), 32'd0);

        // Enable pattern 1,0,1,1 carrying saturating, Gx-only and Gy-only windows
        applyStimulus(1'b1, W_R255);
        applyStimulus(1'b0, '0);
        checkOutput("gap_pre_valid", 32'(bus.pix_valid_o), 32'd0);
        applyStimulus(1'b1, W_GX80);
        checkPixel("r255", expPix(1020), 1, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, W_GY200);
        checkOutput("gap_valid", 32'(bus.pix_valid_o), 32'd0);
        checkOutput("gap_col_hold", 32'(bus.out_col_o), 32'd1);
        applyStimulus(1'b0, '0);
        checkPixel("gx80", expPix(80), 2, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0);
        checkPixel("gy200", expPix(200), 3, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0);
        checkOutput("gap_post_valid", 32'(bus.pix_valid_o), 32'd0);

        // Back-to-back: mixed signs, negative Gx, saturation boundary 254/256
        applyStimulus(1'b1, W_D22);
        applyStimulus(1'b1, W_NEGL);
        applyStimulus(1'b1, W_G254);
        checkPixel("d22", expPix(200), 4, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, W_G256);
        checkPixel("negl", expPix(1020), 5, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0);
        checkPixel("g254", expPix(254), 0, 1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0);
        checkPixel("g256", expPix(256), 1, 1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0);
        checkOutput("idle_valid", 32'(bus.pix_valid_o), 32'd0);
        checkOutput("idle_rowdone", 32'(bus.row_done_o), 32'd0);

        // Reset with two windows in flight
        applyStimulus(1'b1, W_FLAT);
        applyStimulus(1'b1, W_FLAT);
        rst = 1'b1;
        applyStimulus(1'b0, '0);
        rst = 1'b0;
        checkOutput("midrst_valid", 32'(bus.pix_valid_o), 32'd0);
        checkOutput("midrst_col", 32'(bus.out_col_o), 32'd0);
        checkOutput("midrst_row", 32'(bus.out_row_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0);
            checkOutput($sformatf("midrst_drain%0d", i), 32'(bus.pix_valid_o), 32'd0);
        end

        // Full frame of 18 windows plus one more to show the wrap to (0,0)
        for (int i = 0; i < 21; i++) begin
            applyStimulus(i < 19, W_D00);
            if (i >= 2) begin
                int n;
                n = i - 2;
                checkPixel($sformatf("frame%0d", n), expPix(200), n % 6, (n / 6) % 3,
                           (n % 6) == 5 && n < 18, n == 17);
            end
        end
        applyStimulus(1'b0, '0);
        checkOutput("frame_end_valid", 32'(bus.pix_valid_o), 32'd0);
        checkOutput("frame_end_framedone", 32'(bus.frame_done_o), 32'd0);

`ifdef SOBEL_THRESH_EN
        // Binarize at threshold 80: magnitude 80 passes, 78 does not
        thr_level = 80;
        applyStimulus(1'b1, W_GX80);
        applyStimulus(1'b1, W_G78);
        applyStimulus(1'b0, '0);
        checkPixel("thr_80", 32'd255, 1, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0);
        checkPixel("thr_78", 32'd0, 2, 0, 1'b0, 1'b0);
        // Threshold only matters on the cycle the window is in S2
        thr_level = 200;
        applyStimulus(1'b1, W_GX80);
        thr_level = 80;
        applyStimulus(1'b0, '0);
        thr_level = 200;
        applyStimulus(1'b0, '0);
        checkPixel("thr_s2", 32'd255, 3, 0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
